// File: rtl/output_fifo_reader.sv
// Drain-side controller for the PE-group output FIFO. It serves multi-cycle
// custom-instruction reads: pop, status, peek and flush.
module output_fifo_reader #(
  parameter int DataWidth    = 32,
  parameter int BufferSize   = 16,
  parameter int CountWidth   = 5,
  parameter int TimeoutWidth = 10
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [1:0]            n,
  output logic [DataWidth-1:0]  result,
  output logic                  done,
  output logic                  busy,
  input  logic [BufferSize-1:0] fifo_ready,
  input  logic                  fifo_full,
  input  logic [DataWidth-1:0]  fifo_data,
  output logic                  fifo_pop
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] POP   = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [1:0] CMD_READ   = 2'd0;
  localparam logic [1:0] CMD_STATUS = 2'd1;
  localparam logic [1:0] CMD_PEEK   = 2'd2;
  localparam logic [1:0] CMD_FLUSH  = 2'd3;

  function automatic logic [CountWidth-1:0] popcount(input logic [BufferSize-1:0] v);
    logic [CountWidth-1:0] c;
    c = '0;
    for (int i = 0; i < BufferSize; i++) c = c + CountWidth'(v[i]);
    return c;
  endfunction

  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
    return (&v) ? v : v + CountWidth'(1);
  endfunction

  // Status layout: timeout at bit 9, full at bit 8, occupancy in the low bits.
  function automatic logic [DataWidth-1:0] status_word(input logic sticky,
                                                       input logic full,
                                                       input logic [CountWidth-1:0] cnt);
    logic [DataWidth-1:0] w;
    w = '0;
    w[9] = sticky;
    w[8] = full;
    w[CountWidth-1:0] = cnt;
    return w;
  endfunction

  logic [2:0]              state;
  logic [TimeoutWidth-1:0] wait_cnt;
  logic [CountWidth-1:0]   flush_cnt;
  logic                    timeout_sticky;
  logic [CountWidth-1:0]   count;
  logic                    empty;

  assign count    = popcount(fifo_ready);
  assign empty    = (count == '0);
  assign fifo_pop = clk_en & ((state == POP) | ((state == FLUSH) & ~empty));
  assign done     = (state == DONE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state          <= IDLE;
      result         <= '0;
      wait_cnt       <= '0;
      flush_cnt      <= '0;
      timeout_sticky <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (start) begin
            case (n)
              CMD_READ: begin
                wait_cnt <= '0;
                state    <= empty ? WAIT : POP;
              end
              CMD_STATUS: begin
                result         <= status_word(timeout_sticky, fifo_full, count);
                timeout_sticky <= 1'b0;
                state          <= DONE;
              end
              CMD_PEEK: begin
                result <= empty ? '0 : fifo_data;
                state  <= DONE;
              end
              CMD_FLUSH: begin
                flush_cnt <= '0;
                state     <= FLUSH;
              end
            endcase
          end
        end
        // A word arriving on the terminal-count cycle takes priority over timeout.
        WAIT: begin
          if (!empty) begin
            state <= POP;
          end else if (&wait_cnt) begin
            result         <= '0;
            timeout_sticky <= 1'b1;
            state          <= DONE;
          end else begin
            wait_cnt <= wait_cnt + TimeoutWidth'(1);
          end
        end
        POP: begin
          result <= fifo_data;
          state  <= DONE;
        end
        FLUSH: begin
          if (!empty) begin
            flush_cnt <= sat_inc(flush_cnt);
          end else begin
            result <= DataWidth'(flush_cnt);
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_fifo_reader.sv
// Bench for output_fifo_reader: a behavioural 16-entry FIFO feeds the reader,
// directed commands queue their expected results and are checked on done.
module tb_output_fifo_reader;
  localparam int DW = 32;
  localparam int BS = 16;
  localparam logic [1:0] READ = 2'd0, STATUS = 2'd1, PEEK = 2'd2, FLUSH = 2'd3;

  logic          clk = 1'b0;
  logic          aclr, clk_en, start;
  logic [1:0]    n;
  logic [DW-1:0] result;
  logic          done, busy;
  logic [BS-1:0] fifo_ready;
  logic          fifo_full;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  output_fifo_reader dut (
    .clk(clk), .aclr(aclr), .clk_en(clk_en), .start(start), .n(n),
    .result(result), .done(done), .busy(busy),
    .fifo_ready(fifo_ready), .fifo_full(fifo_full), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop)
  );

  always #5 clk = ~clk;

  // FIFO model: occupancy bitmap derived from read pointer and count.
  logic [DW-1:0] mem [BS];
  logic [3:0]    rd_ptr = '0;
  logic [3:0]    wr_ptr = '0;
  int            occ = 0;
  int            pops = 0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;

  always @(posedge clk) begin
    int o;
    o = occ;
    if (fifo_pop) begin
      pops <= pops + 1;
      if (o > 0) begin
        rd_ptr <= rd_ptr + 4'd1;
        o = o - 1;
      end
    end
    if (push && occ < BS) begin
      mem[wr_ptr] <= push_data;
      wr_ptr <= wr_ptr + 4'd1;
      o = o + 1;
    end
    occ <= o;
  end

  always_comb begin
    logic [3:0] d;
    fifo_ready = '0;
    for (int i = 0; i < BS; i++) begin
      d = 4'(i) - rd_ptr;
      if (int'(d) < occ) fifo_ready[i] = 1'b1;
    end
  end
  assign fifo_full = (occ == BS);
  assign fifo_data = mem[rd_ptr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    @(negedge clk);
    push = 1'b1;
    push_data = v;
    @(negedge clk);
    push = 1'b0;
  endtask

  // Issue one instruction; optional push at wait cycle push_at and a 4-cycle
  // clk_en gap starting at gate_at. Latency counts cycles after the start edge.
  task automatic run_cmd(input string tag, input logic [1:0] cmd, input logic [31:0] exp,
                         input int exp_lat, input int budget, input int push_at,
                         input logic [31:0] push_val, input int gate_at);
    int lat;
    int gated_pops;
    logic got;
    logic [31:0] e;
    lat = 0;
    gated_pops = 0;
    got = 1'b0;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b1;
    n = cmd;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      push = (lat == push_at);
      push_data = push_val;
      clk_en = !(gate_at > 0 && lat >= gate_at && lat < gate_at + 4);
      #1;
      if (!clk_en && fifo_pop) gated_pops++;
      if (done) got = 1'b1;
    end
    push = 1'b0;
    clk_en = 1'b1;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    e = exp_q.pop_front();
    if (got) begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, result, e);
    end
    if (gate_at > 0) check({tag, "_gated_pops"}, 32'(gated_pops), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int p0;
    aclr = 1'b0;
    clk_en = 1'b1;
    start = 1'b0;
    n = READ;
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pop", 32'(fifo_pop), 32'd0);
    aclr = 1'b1;
    @(negedge clk);

    // READ on a three-word FIFO
    push_word(32'hA1); push_word(32'hA2); push_word(32'hA3);
    p0 = pops;
    run_cmd("read_a1", READ, 32'hA1, 2, 20, -1, 0, 0);
    check("read_a1_pops", 32'(pops - p0), 32'd1);
    run_cmd("status_cnt2", STATUS, 32'h002, 1, 20, -1, 0, 0);
    run_cmd("flush_2", FLUSH, 32'd2, 4, 30, -1, 0, 0);

    // READ on empty FIFO, word arrives at wait cycle 7
    run_cmd("read_wait", READ, 32'h55, 10, 50, 7, 32'h55, 0);

    // Timeout then sticky status
    run_cmd("read_timeout", READ, 32'd0, 1025, 1100, -1, 0, 0);
    run_cmd("status_sticky", STATUS, 32'h200, 1, 20, -1, 0, 0);
    run_cmd("status_cleared", STATUS, 32'h000, 1, 20, -1, 0, 0);

    // Full FIFO: status, peek, unchanged count, flush all
    for (int i = 0; i < BS; i++) push_word(32'h100 + 32'(i));
    run_cmd("status_full", STATUS, 32'h110, 1, 20, -1, 0, 0);
    p0 = pops;
    run_cmd("peek_first", PEEK, 32'h100, 1, 20, -1, 0, 0);
    check("peek_pops", 32'(pops - p0), 32'd0);
    run_cmd("status_after_peek", STATUS, 32'h110, 1, 20, -1, 0, 0);
    run_cmd("flush_16", FLUSH, 32'd16, 18, 40, -1, 0, 0);

    // Five-word flush
    for (int i = 0; i < 5; i++) push_word(32'hB0 + 32'(i));
    p0 = pops;
    run_cmd("flush_5", FLUSH, 32'd5, 7, 30, -1, 0, 0);
    check("flush_5_pops", 32'(pops - p0), 32'd5);

    // Asynchronous reset during WAIT
    @(negedge clk);
    start = 1'b1;
    n = READ;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    aclr = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    aclr = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_no_done", 32'(done), 32'd0);
    run_cmd("status_after_arst", STATUS, 32'h000, 1, 20, -1, 0, 0);
    run_cmd("peek_empty", PEEK, 32'h000, 1, 20, -1, 0, 0);
    push_word(32'h77);
    run_cmd("read_after_arst", READ, 32'h77, 2, 20, -1, 0, 0);

    // FLUSH with clk_en gap after the first pop
    push_word(32'hC1); push_word(32'hC2); push_word(32'hC3);
    p0 = pops;
    run_cmd("flush_gated", FLUSH, 32'd3, 9, 40, -1, 0, 2);
    check("flush_gated_pops", 32'(pops - p0), 32'd3);
    run_cmd("status_end", STATUS, 32'h000, 1, 20, -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
